gf16_inv_pipe: RTL and testbench

- Multi-lane, pipelined GF(2^4) inverter/squarer with valid/ready flow control on input and output.
- Serves as the nibble-level nonlinear core for tower-field S-box datapaths that process several nibbles per cycle under backpressure.
- Every lane is the same: the element is processed per transaction in the mode selected by `in_mode`.

---
 rtl/gf16_inv_pipe.sv | 131 +++++++++++++
 tb/tb_gf16_inv_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf16_inv_pipe.sv
// Multi-lane pipelined GF(2^4) inverter/squarer (field x^4+x+1) with valid/ready flow control.
// Optional macro GF16_INV_ZERO_FLAG_EN adds a per-lane out_zero flag for zero input nibbles.
module gf16_inv_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [4*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_data
`ifdef GF16_INV_ZERO_FLAG_EN
  ,
  output logic [LANES-1:0]     out_zero
`endif
);

  localparam int W    = 4 * LANES;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] mode_q, mode_d;
  logic [W-1:0]      data_q [STAGES];
  logic [W-1:0]      data_d [STAGES];
  logic [STAGES-1:0] stage_free;

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_sq(input logic [3:0] a);
    return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
  endfunction

  // a^14 via the addition chain 2,3,6,12,14; zero maps to zero naturally
  function automatic logic [3:0] gf_inv(input logic [3:0] a);
    logic [3:0] a2, a3, a12;
    a2  = gf_sq(a);
    a3  = gf_mul(a2, a);
    a12 = gf_sq(gf_sq(a3));
    return gf_mul(a12, a2);
  endfunction

  // A stage can accept when it or any stage below it is empty, or the output drains
  always_comb begin
    logic occupied;
    stage_free = '0;
    for (int s = 0; s < STAGES; s++) begin
      occupied = 1'b1;
      for (int j = s; j < STAGES; j++) begin
        occupied = occupied & valid_q[j];
      end
      stage_free[s] = ~occupied | out_ready;
    end
  end

  assign in_ready = stage_free[0] & ~rst;

  always_comb begin
    valid_d = valid_q;
    mode_d  = mode_q;
    for (int s = 0; s < STAGES; s++) begin
      data_d[s] = data_q[s];
    end
    if (stage_free[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        data_d[0] = in_data;
        mode_d[0] = in_mode;
      end
    end
    for (int s = 1; s < STAGES; s++) begin
      if (stage_free[s]) begin
        valid_d[s] = valid_q[s-1];
        if (valid_q[s-1]) begin
          data_d[s] = data_q[s-1];
          mode_d[s] = mode_q[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      mode_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      mode_q  <= mode_d;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

  assign out_valid = valid_q[LAST];

  // Field operation sits after the last register so the output depends on that stage alone
  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) begin
      out_data[4*k +: 4] = mode_q[LAST] ? gf_sq(data_q[LAST][4*k +: 4])
                                        : gf_inv(data_q[LAST][4*k +: 4]);
    end
  end

`ifdef GF16_INV_ZERO_FLAG_EN
  always_comb begin
    out_zero = '0;
    for (int k = 0; k < LANES; k++) begin
      out_zero[k] = valid_q[LAST] & (data_q[LAST][4*k +: 4] == 4'h0);
    end
  end
`endif

endmodule

// File: tb/tb_gf16_inv_pipe.sv
// Self-checking bench for gf16_inv_pipe: randomized and directed traffic against a
// polynomial-arithmetic reference model with a FIFO scoreboard.
module tb_gf16_inv_pipe;

   localparam int LANES  = 4;
   localparam int STAGES = 2;
   localparam int W      = 4 * LANES;

   logic clk;
   logic rst;
   logic in_valid;
   logic in_ready;
   logic in_mode;
   logic [W-1:0] in_data;
   logic out_valid;
   logic out_ready;
   logic [W-1:0] out_data;
`ifdef GF16_INV_ZERO_FLAG_EN
   logic [LANES-1:0] out_zero;
`endif

   typedef struct {
      logic [W-1:0]     data;
      logic [LANES-1:0] zero;
      int               acc;
   } exp_t;

   exp_t         expQ[$];
   logic [W-1:0] outLog[$];
   int           nTests = 0;
   int           nFail = 0;
   int           cyc = 0;
   int           nAccept = 0;
   bit           latCheck = 0;

   gf16_inv_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_mode(in_mode),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef GF16_INV_ZERO_FLAG_EN
      ,
      .out_zero(out_zero)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck design still ends the run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Carry-less polynomial product reduced modulo x^4+x+1
   function automatic int refMul(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 4; i++) begin
         if (((b >> i) & 1) != 0) p = p ^ (a << i);
      end
      for (int bitPos = 6; bitPos >= 4; bitPos--) begin
         if (((p >> bitPos) & 1) != 0) p = p ^ (32'h13 << (bitPos - 4));
      end
      return p & 15;
   endfunction

   // Inverse by search for the element whose product is one
   function automatic int refInv(input int a);
      int r;
      r = 0;
      for (int b = 1; b < 16; b++) begin
         if (a != 0 && refMul(a, b) == 1) r = b;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] refWord(input logic [W-1:0] d, input logic m);
      logic [W-1:0] r;
      int a;
      r = '0;
      for (int k = 0; k < LANES; k++) begin
         a = int'(d[4*k +: 4]);
         r[4*k +: 4] = 4'(m ? refMul(a, a) : refInv(a));
      end
      return r;
   endfunction

   function automatic logic [LANES-1:0] refZero(input logic [W-1:0] d);
      logic [LANES-1:0] z;
      for (int k = 0; k < LANES; k++) begin
         z[k] = (d[4*k +: 4] == 4'h0);
      end
      return z;
   endfunction

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, score any output transfer, record any accept
   task automatic applyStimulus(input logic v, input logic m, input logic [W-1:0] d, input logic r);
      exp_t e;
      in_valid  = v;
      in_mode   = m;
      in_data   = d;
      out_ready = r;
      #1;
      if (out_valid && out_ready) begin
         outLog.push_back(out_data);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("data", 64'(out_data), 64'(e.data));
`ifdef GF16_INV_ZERO_FLAG_EN
            checkOutput("zero_flag", 64'(out_zero), 64'(e.zero));
`endif
            if (latCheck) checkOutput("latency", 64'(cyc - e.acc), 64'(STAGES));
         end
      end
      if (in_valid && in_ready) begin
         e.data = refWord(d, m);
         e.zero = refZero(d);
         e.acc  = cyc;
         expQ.push_back(e);
         nAccept++;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b1);
      end
      checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
   endtask

   function automatic logic [W-1:0] randData();
      logic [W-1:0] d;
      for (int k = 0; k < LANES; k++) begin
         d[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      end
      return d;
   endfunction

   initial begin
      int base;
      logic [W-1:0] held;
      bit haveHeld;

      rst = 1'b1;
      in_valid = 1'b0;
      in_mode = 1'b0;
      in_data = '0;
      out_ready = 1'b0;

      #3;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_data", 64'(out_data), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("ready_after_rst", 64'(in_ready), 64'd1);

      // Exhaustive inverse: every lane sees all 16 nibbles, latency checked per item
      latCheck = 1;
      base = nAccept;
      for (int i = 0; i < 16; i++) begin
         logic [W-1:0] d;
         for (int k = 0; k < LANES; k++) d[4*k +: 4] = 4'((i + k) & 15);
         applyStimulus(1'b1, 1'b0, d, 1'b1);
      end
      checkOutput("exh_accepts", 64'(nAccept - base), 64'd16);
      drain();
      latCheck = 0;

      // Directed square vector
      outLog.delete();
      applyStimulus(1'b1, 1'b1, 16'h321F, 1'b1);
      drain();
      checkOutput("sq_count", 64'(outLog.size()), 64'd1);
      if (outLog.size() > 0) checkOutput("sq_vec", 64'(outLog[0]), 64'h541A);

      // Mixed modes on the same operand
      outLog.delete();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, i[0], 16'h2222, 1'b1);
      drain();
      checkOutput("mixed_count", 64'(outLog.size()), 64'd8);
      for (int i = 0; i < outLog.size(); i++) begin
         checkOutput("mixed_val", 64'(outLog[i]), (i % 2 == 1) ? 64'h4444 : 64'h9999);
      end

      // Backpressure: fill, confirm stall and hold, then release
      base = nAccept;
      haveHeld = 0;
      held = '0;
      for (int i = 0; i < STAGES + 3; i++) begin
         applyStimulus(1'b1, 1'($urandom), randData(), 1'b0);
         if (out_valid) begin
            if (!haveHeld) begin
               held = out_data;
               haveHeld = 1;
            end else begin
               checkOutput("bp_hold", 64'(out_data), 64'(held));
            end
         end
      end
      checkOutput("bp_accepts", 64'(nAccept - base), 64'(STAGES));
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'($urandom), randData(), 1'b1);
      drain();

      // Asynchronous reset with the pipeline full
      for (int i = 0; i < STAGES; i++) applyStimulus(1'b1, 1'b0, randData(), 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("mid_rst_out_data", 64'(out_data), 64'd0);
      checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd0);
      expQ.delete();
      @(posedge clk);
      cyc++;
      #1;
      checkOutput("held_rst_in_ready", 64'(in_ready), 64'd0);
      checkOutput("held_rst_out_valid", 64'(out_valid), 64'd0);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("ready_after_mid_rst", 64'(in_ready), 64'd1);
      latCheck = 1;
      outLog.delete();
      applyStimulus(1'b1, 1'b0, 16'h0001, 1'b1);
      for (int i = 0; i < STAGES + 3; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("post_rst_count", 64'(outLog.size()), 64'd1);
      drain();
      latCheck = 0;

`ifdef GF16_INV_ZERO_FLAG_EN
      // Zero flag aligned with data and held under backpressure
      applyStimulus(1'b1, 1'b0, 16'h0507, 1'b0);
      for (int i = 0; i < STAGES + 1; i++) begin
         applyStimulus(1'b0, 1'b0, '0, 1'b0);
         if (out_valid) checkOutput("zero_hold", 64'(out_zero), 64'b1010);
      end
      drain();
`endif

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom), 1'($urandom), randData(), ($urandom_range(0, 3) != 0));
      end
      drain();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
